mode_sequencer: RTL

//   Clocked controller for the calculator datapath. It debounces the two KEY buttons and

---
 rtl/mode_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
// Mode/operation controller: debounced KEY stepping of MODE, manual or auto-demo OPERATION,
// and an auto-demo scheduler walking all sixteen {MODE,OPERATION} pairs.
module mode_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int AUTO_PERIOD     = 50000000
) (
   input  logic       MAX10_CLK1_50,
   input  logic       RST_N,
   input  logic [1:0] KEY,
   input  logic       AUTO_EN,
   input  logic [1:0] SW_OP,
   output logic [1:0] MODE,
   output logic [1:0] OPERATION,
   output logic       AUTO_ACTIVE,
   output logic       STEP
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(AUTO_PERIOD);
   localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

   state_t          state_q, state_n;
   logic [1:0]      key_s1, key_s2;
   logic            auto_s1, auto_s2;
   logic [1:0]      deb, deb_q;
   logic [DW-1:0]   db_cnt [2];
   logic [TW-1:0]   timer_q, timer_n;
   logic [1:0]      mode_q, mode_n, op_q, op_n;
   logic            step_q, step_n;
   logic [1:0]      press;
   logic            chord;

   // Input synchronizers and per-key debounce; deb_q delays deb by one cycle for edge detection.
   always_ff @(posedge MAX10_CLK1_50 or negedge RST_N) begin
      if (!RST_N) begin
         key_s1  <= 2'b11;
         key_s2  <= 2'b11;
         auto_s1 <= 1'b0;
         auto_s2 <= 1'b0;
         deb     <= 2'b11;
         deb_q   <= 2'b11;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         key_s1  <= KEY;
         key_s2  <= key_s1;
         auto_s1 <= AUTO_EN;
         auto_s2 <= auto_s1;
         deb_q   <= deb;
         for (int i = 0; i < 2; i++) begin
            if (key_s2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= key_s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign press = deb_q & ~deb;
   // A press counts as a chord if the other key is already (or simultaneously) down.
   assign chord = (press[0] & ~deb[1]) | (press[1] & ~deb[0]);

   always_ff @(posedge MAX10_CLK1_50 or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= MANUAL;
         mode_q  <= 2'd0;
         op_q    <= 2'd0;
         timer_q <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         mode_q  <= mode_n;
         op_q    <= op_n;
         timer_q <= timer_n;
         step_q  <= step_n;
      end
   end

   always_comb begin
      state_n = state_q;
      mode_n  = mode_q;
      op_n    = op_q;
      timer_n = timer_q;
      step_n  = 1'b0;
      case (state_q)
         MANUAL: begin
            if (auto_s2) begin
               state_n = AUTO;
               mode_n  = 2'd0;
               op_n    = 2'd0;
               timer_n = '0;
            end else begin
               op_n = SW_OP;
               if (chord)         mode_n = 2'd0;
               else if (press[0]) mode_n = mode_q + 2'd1;
               else if (press[1]) mode_n = mode_q - 2'd1;
            end
         end
         AUTO: begin
            // Exit outranks both chord reset and timer expiry.
            if (!auto_s2) begin
               state_n = MANUAL;
               timer_n = '0;
            end else if (chord) begin
               mode_n  = 2'd0;
               op_n    = 2'd0;
               timer_n = '0;
            end else if (timer_q == TIMER_LAST) begin
               timer_n        = '0;
               step_n         = 1'b1;
               {mode_n, op_n} = {mode_q, op_q} + 4'd1;
            end else begin
               timer_n = timer_q + TW'(1);
            end
         end
         default: state_n = MANUAL;
      endcase
   end

   assign MODE        = mode_q;
   assign OPERATION   = op_q;
   assign AUTO_ACTIVE = (state_q == AUTO);
   assign STEP        = step_q;

endmodule
